seq10_det_scheduler: RTL and testbench

Round-robin scheduler that shares one serial "10" pattern-detector core between `N_REQ` requesters. Each requester presents a parallel word. The scheduler grants one requester at a time, serialises its word MSB-first into the detector, and counts detections. It then returns the match count with a one-cycle `done` pulse tagged with the requester index. It sits between the word-producing clients and the single detector resource.

---
 rtl/seq10_pkg.sv | 20 ++
 rtl/seq10_det_core.sv | 45 ++++
 rtl/seq10_det_scheduler.sv | 158 +++++++++++++++
 tb/tb_seq10_det_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq10_pkg.sv
// Shared types and constants for the round-robin "10" detector scheduler.
// Holds the scheduler state enum, the detector core state codes and default sizes.
package seq10_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FLUSH  = 2'b10,
        REPORT = 2'b11
    } sched_state_e;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

endpackage

// File: rtl/seq10_det_core.sv
// Serial Moore detector for the pattern "10"; z is high while the core sits in S2.
// clr forces S0 and takes priority over the serial input.
module seq10_det_core
    import seq10_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic x,
    output logic z
);

    logic [1:0] state_r;
    logic [1:0] next_s;
    logic       z_r;

    // Next-state logic of the detector.
    always_comb begin
        next_s = S0;
        if (clr) begin
            next_s = S0;
        end else begin
            case (state_r)
                S0:      next_s = x ? S1 : S0;
                S1:      next_s = x ? S1 : S2;
                S2:      next_s = x ? S1 : S0;
                default: next_s = S0;
            endcase
        end
    end

    // State register; z is registered alongside so it equals (state == S2).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S0;
            z_r     <= 1'b0;
        end else begin
            state_r <= next_s;
            z_r     <= (next_s == S2);
        end
    end

    assign z = z_r;

endmodule

// File: rtl/seq10_det_scheduler.sv
// Round-robin scheduler sharing one serial "10" detector among N_REQ requesters.
// Grants one requester, shifts its word MSB-first into the core, and reports the match count.
module seq10_det_scheduler
    import seq10_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int ID_W  = $clog2(N_REQ),
    localparam int BC_W  = $clog2(WORD_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   word,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic [CNT_W-1:0]          match_cnt
);

    sched_state_e       state_r;
    logic [N_REQ-1:0]   gnt_r;
    logic               busy_r;
    logic               done_r;
    logic [ID_W-1:0]    done_id_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WORD_W-1:0]  shreg_r;
    logic [BC_W-1:0]    bitcnt_r;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    cur_id_r;

    logic [ID_W:0]      pick_s;
    logic               pick_found_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic [WORD_W-1:0]  sel_word_s;
    logic [N_REQ-1:0]   pick_onehot_s;
    logic               core_clr_s;
    logic               core_x_s;
    logic               core_z_s;

    // First requesting index at or after ptr, wrapping; MSB of the result flags "found".
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + ID_W'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s       = rr_pick(req, ptr_r);
    assign pick_found_s = pick_s[ID_W];
    assign pick_idx_s   = pick_s[ID_W-1:0];

    // Payload and one-hot grant for the candidate requester.
    always_comb begin
        sel_word_s    = '0;
        pick_onehot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_s == ID_W'(i)) begin
                sel_word_s       = word[i*WORD_W +: WORD_W];
                pick_onehot_s[i] = 1'b1;
            end else begin
                pick_onehot_s[i] = 1'b0;
            end
        end
    end

    assign core_clr_s = (state_r == IDLE);
    assign core_x_s   = (state_r == SHIFT) ? shreg_r[WORD_W-1] : 1'b0;

    seq10_det_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (core_clr_s),
        .x   (core_x_s),
        .z   (core_z_s)
    );

    // Service FSM: grant, shift, flush, report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            done_id_r   <= '0;
            match_cnt_r <= '0;
            cnt_r       <= '0;
            shreg_r     <= '0;
            bitcnt_r    <= '0;
            ptr_r       <= '0;
            cur_id_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        gnt_r    <= pick_onehot_s;
                        busy_r   <= 1'b1;
                        shreg_r  <= sel_word_s;
                        bitcnt_r <= BC_W'(WORD_W);
                        cnt_r    <= '0;
                        cur_id_r <= pick_idx_s;
                        ptr_r    <= pick_idx_s + ID_W'(1);
                        state_r  <= SHIFT;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg_r  <= shreg_r << 1;
                    bitcnt_r <= bitcnt_r - BC_W'(1);
                    cnt_r    <= cnt_r + CNT_W'(core_z_s);
                    if (bitcnt_r == BC_W'(1)) begin
                        state_r <= FLUSH;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                FLUSH: begin
                    // Final core sample is folded straight into the reported count.
                    match_cnt_r <= cnt_r + CNT_W'(core_z_s);
                    done_r      <= 1'b1;
                    done_id_r   <= cur_id_r;
                    gnt_r       <= '0;
                    state_r     <= REPORT;
                end
                REPORT: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign done_id   = done_id_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_seq10_det_scheduler.sv
// Self-checking bench for seq10_det_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level timing model of the scheduler.
module tb_seq10_det_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] word;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    done;
    logic [1:0]              done_id;
    logic [CNT_W-1:0]        match_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    seq10_det_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word      (word),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    // Occurrences of "10" in a word, overlapping allowed.
    function automatic int count10(input logic [WORD_W-1:0] w);
        int c = 0;
        for (int b = WORD_W - 1; b >= 1; b--) begin
            if (w[b] == 1'b1 && w[b-1] == 1'b0) c++;
        end
        return c;
    endfunction

    // Reference model: one transaction at a time, timed relative to its grant edge.
    int                edge_n  = 0;
    bit                m_has   = 1'b0;
    int                m_ge    = 0;
    int                m_id    = 0;
    int                m_cnt   = 0;
    int                m_ptr   = 0;
    int                m_last  = 0;
    logic [N_REQ-1:0]  e_gnt   = '0;
    bit                e_busy  = 1'b0;
    bit                e_done  = 1'b0;

    always @(posedge clk) begin
        bit found;
        int idx;
        edge_n++;
        if (!rst) begin
            m_has  = 1'b0;
            m_ptr  = 0;
            m_last = 0;
        end else if ((!m_has || edge_n >= m_ge + WORD_W + 3) && req != '0) begin
            found = 1'b0;
            idx   = 0;
            for (int off = 0; off < N_REQ; off++) begin
                if (!found && req[(m_ptr + off) % N_REQ]) begin
                    found = 1'b1;
                    idx   = (m_ptr + off) % N_REQ;
                end
            end
            m_has = 1'b1;
            m_ge  = edge_n;
            m_id  = idx;
            m_cnt = count10(word[idx*WORD_W +: WORD_W]);
            m_ptr = (idx + 1) % N_REQ;
        end
        e_gnt  = (m_has && edge_n >= m_ge && edge_n <= m_ge + WORD_W) ? N_REQ'(1 << m_id) : '0;
        e_busy = m_has && edge_n <= m_ge + WORD_W + 1;
        e_done = m_has && edge_n == m_ge + WORD_W + 1;
        if (e_done) m_last = m_cnt;
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("gnt", gnt, e_gnt);
            check_eq("busy", busy, e_busy);
            check_eq("done", done, e_done);
            check_eq("match_cnt", match_cnt, m_last);
            if (e_done) check_eq("done_id", done_id, m_id);
        end
    end

    task automatic wait_done(input int budget, output bit seen, output int gcyc);
        seen = 1'b0;
        gcyc = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (gnt != '0) gcyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run_one(input string tag, input int id, input logic [WORD_W-1:0] w,
                           input int exp_cnt);
        bit seen;
        int gcyc;
        word[id*WORD_W +: WORD_W] = w;
        req = N_REQ'(1 << id);
        wait_done(25, seen, gcyc);
        req = '0;
        check_eq({tag, "_seen"}, seen, 1);
        check_eq({tag, "_id"}, done_id, id);
        check_eq({tag, "_cnt"}, match_cnt, exp_cnt);
        check_eq({tag, "_gcyc"}, gcyc, WORD_W + 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit seen;
        int gcyc;
        int t_prev;
        logic [WORD_W-1:0] w8;

        rst  = 1'b0;
        req  = 4'b1111;
        word = 32'h0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", match_cnt, 0);
        rst  = 1'b1;
        word = 32'h55F0_AA01;
        @(negedge clk);
        check_eq("first_gnt", gnt, 4'b0001);

        // Fairness: continuous requests rotate 0,1,2,3,0 with an 11-cycle period.
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(30, seen, gcyc);
            check_eq("fair_seen", seen, 1);
            check_eq("fair_id", done_id, k % N_REQ);
            if (k > 0) check_eq("fair_period", edge_n - t_prev, WORD_W + 3);
            t_prev = edge_n;
        end
        req = '0;
        repeat (15) @(negedge clk);

        run_one("single_aa", 0, 8'b10101010, 4);
        run_one("pat_f0", 2, 8'b11110000, 1);
        run_one("pat_55", 2, 8'b01010101, 3);
        run_one("pat_00", 2, 8'b00000000, 0);
        run_one("pat_81", 2, 8'b10000001, 1);

        // Abort during SHIFT of requester 1: no done, priority returns to requester 0.
        word[1*WORD_W +: WORD_W] = 8'b11001100;
        req = 4'b0010;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check_eq("abort_done", done, 0);
        check_eq("abort_cnt", match_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_prio", gnt, 4'b0001);
        req = '0;
        repeat (15) @(negedge clk);

        // Late arrival on requester 3; its word changes before its own grant.
        word[0*WORD_W +: WORD_W] = 8'b10010010;
        req = 4'b0001;
        repeat (3) @(negedge clk);
        word[3*WORD_W +: WORD_W] = 8'b11110000;
        req = 4'b1001;
        wait_done(25, seen, gcyc);
        check_eq("late_first_id", done_id, 0);
        check_eq("late_first_cnt", match_cnt, 3);
        req = 4'b1000;
        word[3*WORD_W +: WORD_W] = 8'b01010101;
        wait_done(25, seen, gcyc);
        check_eq("late_seen", seen, 1);
        check_eq("late_id", done_id, 3);
        check_eq("late_cnt", match_cnt, 3);
        req = '0;
        repeat (4) @(negedge clk);

        // Word changes after the grant are ignored.
        word[1*WORD_W +: WORD_W] = 8'b10101010;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        word[1*WORD_W +: WORD_W] = 8'b00000000;
        wait_done(25, seen, gcyc);
        req = '0;
        check_eq("stable_seen", seen, 1);
        check_eq("stable_cnt", match_cnt, 4);
        repeat (4) @(negedge clk);

        // Random traffic with sticky requests and occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = N_REQ'($urandom_range(0, 15));
            w8 = 8'($urandom);
            word = {$urandom} ^ {24'h0, w8};
            rst = ($urandom_range(0, 149) != 0);
        end
        rst = 1'b1;
        req = '0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
